// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the single GRF write port between the W stage and
// buffered MDU results. The W stage always wins. MDU results wait in a small
// FIFO and drain into free slots. Buffered results that a newer W-stage write
// supersedes are killed. Hazard lookups and a starvation stall are provided.
module grf_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_we,
    input  logic [4:0]               wb_addr,
    input  logic [31:0]              wb_data,
    input  logic [31:0]              wb_pc4,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [4:0]               mdu_addr,
    input  logic [31:0]              mdu_data,
    input  logic [31:0]              mdu_pc4,
    output logic                     grf_we,
    output logic [4:0]               grf_a3,
    output logic [31:0]              grf_wd,
    output logic [31:0]              grf_pc4,
    input  logic [4:0]               q_rs_addr,
    input  logic [4:0]               q_rt_addr,
    output logic                     rs_pending,
    output logic                     rt_pending,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic              vld_r  [DEPTH];
    logic [4:0]        addr_r [DEPTH];
    logic [31:0]       data_r [DEPTH];
    logic [31:0]       pc4_r  [DEPTH];
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [CW-1:0]     count_r;
    logic [SW-1:0]     starve_r;
    logic              stall_req_r;

    logic              wb_own_s;
    logic              head_occ_s;
    logic              head_vld_s;
    logic              head_grant_s;
    logic              pop_s;
    logic              push_s;
    logic              ready_s;
    logic              rs_hit_s;
    logic              rt_hit_s;
    logic [CW-1:0]     count_next_s;
    logic [SW-1:0]     starve_next_s;

    // Port ownership and FIFO handshake decisions for this cycle.
    always_comb begin
        wb_own_s     = wb_we && (wb_addr != 5'd0);
        head_occ_s   = (count_r != {CW{1'b0}});
        head_vld_s   = head_occ_s && vld_r[rd_ptr_r];
        head_grant_s = !wb_own_s && head_vld_s;
        // A killed head retires even while the W stage holds the port.
        pop_s        = head_occ_s && (!vld_r[rd_ptr_r] || head_grant_s);
        ready_s      = (count_r < CW'(DEPTH));
        // Writes to $0 are acknowledged but never stored.
        push_s       = mdu_valid && ready_s && (mdu_addr != 5'd0);
    end

    // Occupancy after this edge's push and pop.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Drive the GRF write port from the owner selected above.
    always_comb begin
        if (wb_own_s) begin
            grf_we  = 1'b1;
            grf_a3  = wb_addr;
            grf_wd  = wb_data;
            grf_pc4 = wb_pc4;
        end else if (head_grant_s) begin
            grf_we  = 1'b1;
            grf_a3  = addr_r[rd_ptr_r];
            grf_wd  = data_r[rd_ptr_r];
            grf_pc4 = pc4_r[rd_ptr_r];
        end else begin
            grf_we  = 1'b0;
            grf_a3  = 5'd0;
            grf_wd  = 32'd0;
            grf_pc4 = wb_pc4;
        end
    end

    // Hazard lookup: valid bits are only ever set on occupied slots.
    always_comb begin
        rs_hit_s = 1'b0;
        rt_hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rs_hit_s = rs_hit_s | (vld_r[i] && (addr_r[i] == q_rs_addr));
            rt_hit_s = rt_hit_s | (vld_r[i] && (addr_r[i] == q_rt_addr));
        end
        rs_pending = (q_rs_addr != 5'd0) && rs_hit_s;
        rt_pending = (q_rt_addr != 5'd0) && rt_hit_s;
    end

    // Next starvation count: clear on pop or empty, otherwise count waiting cycles.
    always_comb begin
        if (pop_s || !head_occ_s) begin
            starve_next_s = {SW{1'b0}};
        end else if (head_vld_s && !head_grant_s && (starve_r < SW'(STARVE_LIMIT))) begin
            starve_next_s = starve_r + SW'(1);
        end else begin
            starve_next_s = starve_r;
        end
    end

    // FIFO storage, pointers and the kill of superseded entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_r[i]  <= 1'b0;
                addr_r[i] <= 5'd0;
                data_r[i] <= 32'd0;
                pc4_r[i]  <= 32'd0;
            end
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_own_s && (addr_r[i] == wb_addr)) begin
                    vld_r[i] <= 1'b0;
                end
            end
            if (pop_s) begin
                vld_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r        <= rd_ptr_r + PW'(1);
            end
            // Push and pop never target the same slot: push needs a free slot, pop an occupied one.
            if (push_s) begin
                vld_r[wr_ptr_r]  <= !(wb_own_s && (mdu_addr == wb_addr));
                addr_r[wr_ptr_r] <= mdu_addr;
                data_r[wr_ptr_r] <= mdu_data;
                pc4_r[wr_ptr_r]  <= mdu_pc4;
                wr_ptr_r         <= wr_ptr_r + PW'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Starvation counter and its registered stall request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_r    <= {SW{1'b0}};
            stall_req_r <= 1'b0;
        end else begin
            starve_r    <= starve_next_s;
            stall_req_r <= (starve_next_s >= SW'(STARVE_LIMIT));
        end
    end

    assign mdu_ready  = ready_s;
    assign stall_req  = stall_req_r;
    assign fifo_count = count_r;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Scoreboard bench for grf_wb_arbiter: a queue-based model predicts every GRF
// write. A separate monitor pops and compares the predictions whenever the DUT
// asserts grf_we.
module tb_grf_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc4;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic [31:0] mdu_pc4;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc4;
    logic [4:0]  q_rs_addr;
    logic [4:0]  q_rt_addr;
    logic        rs_pending;
    logic        rt_pending;
    logic        stall_req;
    logic [2:0]  fifo_count;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] p;
        logic        v;
    } ent_t;

    ent_t m_q[$];     // model of the buffered MDU results, oldest first
    ent_t src_q[$];   // MDU results waiting to be offered
    ent_t exp_q[$];   // predicted GRF writes
    ent_t mon_e;
    int   sc;
    logic stall_m;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    grf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc4(wb_pc4),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr),
        .mdu_data(mdu_data), .mdu_pc4(mdu_pc4),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc4(grf_pc4),
        .q_rs_addr(q_rs_addr), .q_rt_addr(q_rt_addr),
        .rs_pending(rs_pending), .rt_pending(rt_pending),
        .stall_req(stall_req), .fifo_count(fifo_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic pend(input logic [4:0] q);
        logic r;
        r = 1'b0;
        if (q != 5'd0) begin
            foreach (m_q[i]) begin
                if (m_q[i].v && (m_q[i].a == q)) r = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic mdu(input logic [4:0] a, input logic [31:0] d);
        ent_t e;
        e.a = a; e.d = d; e.p = $urandom; e.v = 1'b1;
        src_q.push_back(e);
    endtask

    // One clock cycle: drive inputs, check the model's view, predict the write, advance the model.
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        int   sz;
        logic own, rdy, hv, hg, push, acc, pop;
        ent_t e;
        @(negedge clk);
        wb_we   = we && !stall_req;
        wb_addr = wa;
        wb_data = wd;
        wb_pc4  = $urandom;
        if (src_q.size() > 0) begin
            mdu_valid = 1'b1;
            mdu_addr  = src_q[0].a;
            mdu_data  = src_q[0].d;
            mdu_pc4   = src_q[0].p;
        end else begin
            mdu_valid = 1'b0;
            mdu_addr  = 5'($urandom);
            mdu_data  = $urandom;
            mdu_pc4   = $urandom;
        end
        #1;
        sz  = m_q.size();
        own = wb_we && (wb_addr != 5'd0);
        rdy = (sz < DEPTH);
        chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, rdy});
        chk("fifo_count", {29'd0, fifo_count}, 32'(sz));
        chk("rs_pending", {31'd0, rs_pending}, {31'd0, pend(q_rs_addr)});
        chk("rt_pending", {31'd0, rt_pending}, {31'd0, pend(q_rt_addr)});
        chk("stall_req", {31'd0, stall_req}, {31'd0, stall_m});
        hv = (sz > 0) && m_q[0].v;
        hg = !own && hv;
        if (own) begin
            e.a = wb_addr; e.d = wb_data; e.p = wb_pc4; e.v = 1'b1;
            exp_q.push_back(e);
        end else if (hg) begin
            exp_q.push_back(m_q[0]);
        end else begin
            chk("idle_grf_we", {31'd0, grf_we}, 32'd0);
            chk("idle_grf_a3", {27'd0, grf_a3}, 32'd0);
            chk("idle_grf_wd", grf_wd, 32'd0);
            chk("idle_grf_pc4", grf_pc4, wb_pc4);
        end
        acc  = mdu_valid && rdy;
        push = acc && (mdu_addr != 5'd0);
        pop  = (sz > 0) && (!m_q[0].v || hg);
        if (pop) void'(m_q.pop_front());
        if (own) begin
            foreach (m_q[i]) begin
                if (m_q[i].a == wb_addr) m_q[i].v = 1'b0;
            end
        end
        if (push) begin
            e.a = mdu_addr; e.d = mdu_data; e.p = mdu_pc4;
            e.v = !(own && (mdu_addr == wb_addr));
            m_q.push_back(e);
        end
        if (acc) void'(src_q.pop_front());
        if (pop || (sz == 0)) sc = 0;
        else if (hv && !hg && (sc < LIMIT)) sc++;
        stall_m = (sc >= LIMIT);
    endtask

    // Monitor: every DUT write must match the oldest prediction, and no prediction may go unwritten.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (grf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_write: got a3=%0d wd=%h, expected no write at %0t",
                             grf_a3, grf_wd, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("grf_a3", {27'd0, grf_a3}, {27'd0, mon_e.a});
                    chk("grf_wd", grf_wd, mon_e.d);
                    chk("grf_pc4", grf_pc4, mon_e.p);
                end
            end else if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_cmp++; n_fail++;
                $display("FAIL missing_write: got grf_we=%b, expected a3=%0d wd=%h at %0t",
                         grf_we, mon_e.a, mon_e.d, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        sc = 0; stall_m = 1'b0;
        reset = 1'b0; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; wb_pc4 = 32'd0;
        mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0; mdu_pc4 = 32'd0;
        q_rs_addr = 5'd0; q_rt_addr = 5'd0;
        #1;
        chk("reset_mdu_ready", {31'd0, mdu_ready}, 32'd1);
        chk("reset_fifo_count", {29'd0, fifo_count}, 32'd0);
        chk("reset_stall_req", {31'd0, stall_req}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 5'd0, 32'd0);

        // Single MDU result into an idle port.
        q_rs_addr = 5'd5;
        mdu(5'd5, 32'h0000_1234);
        repeat (4) step(1'b0, 5'd0, 32'd0);

        // Fill the FIFO behind continuous W-stage writes; starvation then forces drains.
        q_rs_addr = 5'd3; q_rt_addr = 5'd6;
        for (int i = 1; i <= 5; i++) mdu(i[4:0] == 5'd5 ? 5'd6 : i[4:0], 32'h100 + i);
        repeat (60) step(1'b1, 5'd8, $urandom);
        repeat (3) step(1'b0, 5'd0, 32'd0);

        // Kill: buffered $7 superseded by a W-stage write to $7.
        q_rs_addr = 5'd7;
        mdu(5'd7, 32'h0000_AAAA);
        repeat (2) step(1'b1, 5'd8, $urandom);
        step(1'b1, 5'd7, 32'h0000_BBBB);
        repeat (3) step(1'b0, 5'd0, 32'd0);

        // Same-edge push and kill of $9, then a discarded $0 result.
        q_rs_addr = 5'd9;
        mdu(5'd9, 32'h0000_9999);
        step(1'b1, 5'd9, 32'h0000_0009);
        mdu(5'd0, 32'hDEAD_BEEF);
        repeat (4) step(1'b0, 5'd0, 32'd0);

        // Reset with three buffered entries.
        q_rs_addr = 5'd10; q_rt_addr = 5'd12;
        mdu(5'd10, 32'h10); mdu(5'd11, 32'h11); mdu(5'd12, 32'h12);
        repeat (4) step(1'b1, 5'd8, $urandom);
        @(posedge clk);
        #2;
        reset = 1'b0; wb_we = 1'b0; mdu_valid = 1'b0;
        #1;
        chk("midrst_fifo_count", {29'd0, fifo_count}, 32'd0);
        chk("midrst_mdu_ready", {31'd0, mdu_ready}, 32'd1);
        chk("midrst_rs_pending", {31'd0, rs_pending}, 32'd0);
        chk("midrst_rt_pending", {31'd0, rt_pending}, 32'd0);
        m_q.delete(); src_q.delete(); sc = 0; stall_m = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) step(1'b0, 5'd0, 32'd0);

        // Randomized traffic with frequent address collisions.
        for (int c = 0; c < 600; c++) begin
            if ((src_q.size() == 0) && ($urandom_range(0, 2) == 0))
                mdu(5'($urandom_range(0, 7)), $urandom);
            q_rs_addr = 5'($urandom_range(0, 7));
            q_rt_addr = 5'($urandom_range(0, 7));
            if (c < 300) step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            else step(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 7)), $urandom);
        end
        repeat (40) step(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Shares the single GRF write port between the fixed-timing pipeline writeback stage and the long-latency multiply/divide unit (MDU) result port.
- Buffers MDU results in a DEPTH-entry FIFO and drains them into free writeback slots.
- Suppresses stale MDU writes that are superseded by newer pipeline writes.
- Gives the hazard unit pending-write lookups and a starvation stall request; sits between the W stage, the MDU and GRF.

Parameters:
DEPTH, 4, MDU result FIFO entries; power of two, >= 2
STARVE_LIMIT, 8, cycles a valid FIFO head may wait before stall_req asserts; >= 1

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
wb_we  in  1  W stage write enable
wb_addr  in  5  W stage destination register
wb_data  in  32  W stage write data
wb_pc4  in  32  W stage PC+4, for write logging
mdu_valid  in  1  MDU result offered
mdu_ready  out  1  FIFO can accept an MDU result
mdu_addr  in  5  MDU destination register
mdu_data  in  32  MDU result data
mdu_pc4  in  32  PC+4 of the issuing MDU instruction
grf_we  out  1  GRF WrEn
grf_a3  out  5  GRF A3
grf_wd  out  32  GRF WD
grf_pc4  out  32  GRF PC4
q_rs_addr  in  5  hazard lookup address 1
q_rt_addr  in  5  hazard lookup address 2
rs_pending  out  1  valid FIFO entry targets q_rs_addr
rt_pending  out  1  valid FIFO entry targets q_rt_addr
stall_req  out  1  request the pipeline to free the next writeback slot
fifo_count  out  $clog2(DEPTH)+1  occupied FIFO slots, killed entries included

Behaviour:
- Reset (reset low, asynchronous):
  - Clears read/write pointers, count, per-entry valid bits and the starvation counter.
  - Reset state: mdu_ready=1, stall_req=0, fifo_count=0, rs_pending=rt_pending=0.
  - grf_* reflect the WB inputs only.
  - Reset mid-operation discards all buffered entries; no write is emitted for them.
- Entry fields: valid, addr[4:0], data[31:0], pc4[31:0].
- Enqueue:
  - mdu_ready = (count < DEPTH), registered-state only; no combinational path from any input.
  - Handshake fires when mdu_valid && mdu_ready at the rising edge.
  - mdu_addr==0 is accepted and discarded: not enqueued, count unchanged.
  - The MDU holds addr/data/pc4 stable while valid && !ready.
- Write port grant (combinational):
  - WB owns the port when wb_we && wb_addr!=0. Drives grf_we=1, grf_a3=wb_addr, grf_wd=wb_data, grf_pc4=wb_pc4.
  - Otherwise, if the FIFO head is occupied and valid, the head owns the port. Drives its addr/data/pc4 with grf_we=1; the head pops at the edge.
  - Otherwise grf_we=0, grf_a3=0, grf_wd=0, grf_pc4=wb_pc4.
- Kill rule (MDU results are always older than the W stage instruction):
  - At each edge where WB owns the port with address X, clear valid on every occupied entry whose addr==X.
  - This includes an entry enqueued at the same edge.
- Invalid head:
  - An occupied head with valid=0 pops at the next edge regardless of who owns the port.
  - It never produces grf_we; one killed entry retires per cycle.
- Count update:
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Push is never allowed when count==DEPTH, even if a pop occurs that cycle.
- Pending lookup (combinational):
  - xx_pending = (q_xx_addr!=0) && any occupied valid entry has addr==q_xx_addr.
  - An entry being enqueued this cycle is not visible until the next cycle.
- Starvation:
  - Counter increments each cycle the head is occupied, valid and not granted; saturates at STARVE_LIMIT.
  - Counter clears when the head pops or the FIFO becomes empty.
  - stall_req = (counter >= STARVE_LIMIT), registered.
  - While stall_req=1 the pipeline guarantees wb_we=0 in that cycle, so the head drains.
  - stall_req deasserts the cycle after that pop.
- Latency:
  - MDU result accepted at edge N is written no earlier than edge N+1, provided the port is free.
  - A WB write is never delayed by this block.

Test Plan:
- Reset low mid-stream with 3 entries buffered -> fifo_count=0, mdu_ready=1 immediately; no grf_we for the discarded entries after release.
- MDU pushes $5=0x1234, WB idle -> next cycle grf_we=1, grf_a3=5, grf_wd=0x00001234; fifo_count returns to 0.
- Push 4 entries ($1..$4) while WB writes $8 continuously -> mdu_ready=0 when full; 5th valid held; rs_pending=1 for q_rs_addr=3.
- Same fill with WB never idle -> stall_req=1 after 8 waiting cycles; bench drops wb_we; entries drain one per cycle; stall_req clears after each pop.
- FIFO holds $7=0xAAAA; WB writes $7=0xBBBB; then WB idle -> no further write to $7; killed slot retires in 1 cycle; GRF $7 stays 0xBBBB.
- Same-edge MDU push of $9 and WB write to $9, and a push with mdu_addr=0 -> $9 entry killed; addr 0 accepted, fifo_count unchanged, never written.
